// File: rtl/arinc429_pkg.sv
// ------------------------------------------------------------------
// arinc429_pkg : shared state encoding and word-size constant
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package arinc429_pkg;

  localparam int ARINC_WORD_BITS = 32;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    ARMED    = 2'd1,
    PULSE    = 2'd2,
    NULL     = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/arinc_line_sync.sv
// ------------------------------------------------------------------
// arinc_line_sync : 2-flop synchronizer for one asynchronous RZ line
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module arinc_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arinc429_rx_framer.sv
// ------------------------------------------------------------------
// arinc429_rx_framer : ARINC 429 RZ receiver, frames 32-bit words to RAM
// Option macro: ARINC429_PARITY_CHECK_EN (odd-parity word check).  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module arinc429_rx_framer
  import arinc429_pkg::*;
#(
  parameter int GAP_CYCLES = 48,
  parameter int MIN_PULSE  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       line_A,
  input  logic                       line_B,
  output logic [ARINC_WORD_BITS-1:0] data,
  output logic [3:0]                 wraddress,
  output logic                       wren,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       line_err
);

  localparam int NW = $clog2(GAP_CYCLES + 1);
  localparam int PW = $clog2(MIN_PULSE + 1);
  localparam int BW = $clog2(ARINC_WORD_BITS);
  localparam logic [NW-1:0] GAP_MAX  = NW'(GAP_CYCLES);
  localparam logic [NW-1:0] GAP_LAST = NW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_MIN = PW'(MIN_PULSE);
  localparam logic [BW-1:0] LAST_BIT  = BW'(ARINC_WORD_BITS - 1);

  logic                       a_s, b_s;
  logic                       any_hi, both_hi, both_d;
  logic                       gap_hit, pulse_ok, parity_ok;
  rx_state_t                  state, state_nxt;
  logic [NW-1:0]              null_cnt;
  logic [PW-1:0]              pulse_cnt;
  logic [BW-1:0]              bit_cnt;
  logic                       pulse_bit;
  logic [ARINC_WORD_BITS-1:0] data_sr;
  logic                       word_done;
  logic                       store_bit, word_evt, frame_evt, line_evt;

  arinc_line_sync u_sync_a (.clock(clock), .reset(reset), .din(line_A), .dout(a_s));
  arinc_line_sync u_sync_b (.clock(clock), .reset(reset), .din(line_B), .dout(b_s));

  assign any_hi   = a_s | b_s;
  assign both_hi  = a_s & b_s;
  // the current null clock is the GAP_CYCLES-th one
  assign gap_hit  = !any_hi && (null_cnt >= GAP_LAST);
  assign pulse_ok = (pulse_cnt >= PULSE_MIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT_GAP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (both_hi) begin
      state_nxt = WAIT_GAP;
    end else begin
      case (state)
        WAIT_GAP: if (gap_hit) state_nxt = ARMED;
        ARMED:    if (any_hi)  state_nxt = PULSE;
        PULSE: begin
          if (!any_hi)
            state_nxt = (pulse_ok && bit_cnt == LAST_BIT) ? WAIT_GAP : NULL;
        end
        NULL: begin
          if (any_hi)       state_nxt = PULSE;
          else if (gap_hit) state_nxt = ARMED;
        end
        default: state_nxt = WAIT_GAP;
      endcase
    end
  end

  // a lasting A/B overlap reports once, on its first clock
  always_comb begin
    line_evt  = both_hi & ~both_d;
    store_bit = 1'b0;
    word_evt  = 1'b0;
    frame_evt = 1'b0;
    if (!both_hi) begin
      case (state)
        PULSE: begin
          if (!any_hi && pulse_ok) begin
            store_bit = 1'b1;
            word_evt  = (bit_cnt == LAST_BIT);
          end
        end
        NULL:    frame_evt = gap_hit && (bit_cnt != '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      null_cnt  <= '0;
      pulse_cnt <= '0;
      bit_cnt   <= '0;
      pulse_bit <= 1'b0;
      data_sr   <= '0;
      word_done <= 1'b0;
      both_d    <= 1'b0;
    end else begin
      both_d    <= both_hi;
      word_done <= word_evt;

      if (any_hi)                 null_cnt <= '0;
      else if (state == PULSE)    null_cnt <= NW'(1);
      else if (state_nxt != state) null_cnt <= '0;
      else if (null_cnt != GAP_MAX) null_cnt <= null_cnt + 1'b1;

      if (!any_hi)                    pulse_cnt <= '0;
      else if (state != PULSE)        pulse_cnt <= PW'(1);
      else if (pulse_cnt != PULSE_MIN) pulse_cnt <= pulse_cnt + 1'b1;

      if (state != PULSE && any_hi) pulse_bit <= a_s;

      if (state_nxt == ARMED || state_nxt == WAIT_GAP) bit_cnt <= '0;
      else if (store_bit)                              bit_cnt <= bit_cnt + 1'b1;

      if (store_bit) data_sr[bit_cnt] <= pulse_bit;
    end
  end

`ifdef ARINC429_PARITY_CHECK_EN
  assign parity_ok = ^data_sr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= word_done & ~parity_ok;
  end
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data      <= '0;
      wraddress <= '0;
      wren      <= 1'b0;
      frame_err <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      wren      <= word_done & parity_ok;
      frame_err <= frame_evt;
      line_err  <= line_evt;
      if (word_done && parity_ok) data <= data_sr;
      if (wren) wraddress <= wraddress + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/arinc429_rx_framer.md
ARINC429_RX_FRAMER -- requirements
Module: arinc429_rx_framer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 48, meaning the minimum null clocks (both lines low) that delimit words (1.5 bit times at 12.5 kbps, 400 kHz clock).
REQ-002 SHALL have parameter MIN_PULSE, default 4, meaning the minimum high clocks for a line pulse to count as a bit; shorter pulses are glitches.
REQ-003 SHALL have port clock, input, 1, the single clock for all logic (400 kHz in the FDAU build).
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port line_A, input, 1, the asynchronous RZ "one" line.
REQ-006 SHALL have port line_B, input, 1, the asynchronous RZ "zero" line.
REQ-007 SHALL have port data, output, 32, the last accepted word, bit 1 (label LSB) at data[0].
REQ-008 SHALL have port wraddress, output, 4, the RAM write address of the current word.
REQ-009 SHALL have port wren, output, 1, a one-clock write strobe qualifying data and wraddress.
REQ-010 SHALL have ports parity_err, frame_err and line_err, each output, 1, one-clock error pulses.

Function
REQ-011 SHALL pass line_A and line_B through 2-flop synchronizers; all logic below uses the synchronized values.
REQ-012 SHALL implement states WAIT_GAP, ARMED, PULSE and NULL.
- WAIT_GAP: count null clocks; any high line clears the count; count reaching GAP_CYCLES goes to ARMED.
- ARMED: a rising line goes to PULSE with bit_cnt=0.
- PULSE: count high clocks; at the falling edge, width >= MIN_PULSE stores the bit (A=1, B=0) at data_sr[bit_cnt] and increments bit_cnt, then goes to NULL; width < MIN_PULSE goes to NULL with no bit stored.
- NULL: a rising line goes to PULSE; null count reaching GAP_CYCLES with bit_cnt in 1..31 pulses frame_err, discards the word and goes to ARMED.
REQ-013 SHALL, on the falling edge completing bit 32, complete the word and go to WAIT_GAP, so a 33rd pulse before a full gap is ignored.
REQ-014 SHALL, on word completion, assert wren for exactly one clock on the following clock edge, with data holding all 32 bits at that time.
REQ-015 SHALL increment wraddress on the clock after wren, wrapping from 15 to 0; data holds until the next accepted word.
REQ-016 SHALL, when both synchronized lines are high in the same clock in any state, pulse line_err, discard any partial word and go to WAIT_GAP.
REQ-017 SHALL saturate the pulse and null counters at their terminal value so they never wrap.
REQ-018 SHALL clear bit_cnt on every entry to ARMED and WAIT_GAP.

Reset
REQ-019 SHALL, while reset is high, force state WAIT_GAP, all counters 0, data 0, wraddress 0, and wren, parity_err, frame_err, line_err all 0.
REQ-020 SHALL discard a word in progress when reset is asserted, and SHALL require a full GAP_CYCLES null after reset before accepting the first bit.

Configuration
REQ-021 SHALL, when ARINC429_PARITY_CHECK_EN is defined, check odd parity over all 32 bits: an even-parity word pulses parity_err and gives no wren, no data update and no wraddress increment.
REQ-022 SHALL, when ARINC429_PARITY_CHECK_EN is undefined, write every complete word and tie parity_err to 0.

Structure
REQ-023 SHALL place the state encoding typedef and the ARINC_WORD_BITS=32 constant in the shared package arinc429_pkg.
REQ-024 SHALL implement the 2-flop synchronizer as a single sub-module, arinc_line_sync, instantiated once per line.

Verification
REQ-025 SHALL cover: 60 null clocks, then a word of 32 valid bits (16 high / 16 null clocks each) encoding 0x8000_00A5 -> one wren, data=0x800000A5, wraddress 0 then 1.
REQ-026 SHALL cover: 17 consecutive valid words with gaps -> the 17th write uses wraddress 0 (wrap).
REQ-027 SHALL cover: 20 bits then a 60-clock null -> frame_err one clock, no wren, and the next word is accepted normally.
REQ-028 SHALL cover: a 2-clock pulse on line_A between bits -> no bit stored, and the word is still accepted with correct data.
REQ-029 SHALL cover: line_A and line_B high together at bit 10 -> line_err, no wren; with ARINC429_PARITY_CHECK_EN, a word 0x0000_00A5 -> parity_err, no wren.
REQ-030 SHALL cover: reset asserted at bit 16 -> all outputs 0 immediately, and no write occurs until a gap followed by a full word.
